// File: rtl/gcd_engine.sv
// gcd_engine: multi-cycle GCD with start/busy/done handshake, zero-operand error and step counter
// Ports: CLK, RST_N (async active-low); START, A, B request; BUSY, DONE, ERROR, Y, ITER result.
// Define GCD_BINARY_EN to use Stein's binary algorithm instead of subtract-and-swap.
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] ITER
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb;
  logic zero_op;
`ifdef GCD_BINARY_EN
  logic [$clog2(WIDTH)-1:0] k;
`endif
  assign zero_op = (A == '0) || (B == '0);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    BUSY = state != IDLE;
    DONE = state == FINISH;
    state_nx = state == IDLE ? (START ? (zero_op ? FINISH : CALC) : IDLE) :
               state == CALC ? (ra == rb ? FINISH : CALC) : IDLE;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      ra <= '0;
      rb <= '0;
      ERROR <= 1'b0;
      Y <= '0;
      ITER <= '0;
`ifdef GCD_BINARY_EN
      k <= '0;
`endif
    end else if (state == IDLE && START) begin
      ra <= A;
      rb <= B;
      ITER <= '0;
      Y <= '0;
      ERROR <= zero_op;
`ifdef GCD_BINARY_EN
      k <= '0;
`endif
    end else if (state == CALC) begin
`ifdef GCD_BINARY_EN
      if (ra == rb) Y <= ra << k;
      else begin
        ITER <= ITER + 1'b1;
        if (!ra[0] && !rb[0]) begin
          ra <= ra >> 1;
          rb <= rb >> 1;
          k <= k + 1'b1;
        end else if (!ra[0]) ra <= ra >> 1;
        else if (!rb[0]) rb <= rb >> 1;
        else if (ra > rb) ra <= ra - rb;
        else rb <= rb - ra;
      end
`else
      if (ra == rb) Y <= ra;
      else begin
        ITER <= ITER + 1'b1;
        if (ra > rb) ra <= ra - rb;
        else rb <= rb - ra;
      end
`endif
    end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: scoreboard bench for gcd_engine against an arithmetic GCD model
module tb_gcd_engine;
  localparam int W = 8;
  logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic BUSY, DONE, ERROR;
  logic [W-1:0] Y, ITER;
  gcd_engine #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .Y(Y), .ITER(ITER)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  typedef struct {
    int y;
    int err;
    int iter;
    int at;
  } exp_t;
  exp_t q[$];
  int cmps = 0, errs = 0;
  task automatic chk(string n, int act, int req);
    cmps++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, req, cyc);
    end
  endtask
  function automatic exp_t model(int a, int b, int k);
    exp_t e;
    int x, y, t, s, sh;
    e.y = 0; e.err = 1; e.iter = 0; e.at = k;
    if (a == 0 || b == 0) return e;
    x = a; y = b; s = 0; sh = 0;
`ifdef GCD_BINARY_EN
    while (x != y) begin
      if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; sh++; end
      else if (x % 2 == 0) x /= 2;
      else if (y % 2 == 0) y /= 2;
      else if (x > y) x -= y;
      else y -= x;
      s++;
    end
    e.y = x << sh;
`else
    // Subtract-and-swap performs (sum of Euclid quotients) - 1 subtractions.
    while (y != 0) begin
      s += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    s -= 1;
    e.y = x;
`endif
    e.err = 0;
    e.iter = s;
    e.at = k + s + 1;
    return e;
  endfunction
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && DONE) begin
      if (q.size() == 0) begin
        cmps++;
        errs++;
        $display("FAIL unexpected_done: got DONE=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("y", int'(Y), e.y);
        chk("error", int'(ERROR), e.err);
        chk("iter", int'(ITER), e.iter);
        chk("done_cycle", cyc, e.at);
        chk("busy_in_finish", int'(BUSY), 1);
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 1000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (BUSY) begin
      cmps++;
      errs++;
      $display("FAIL idle_timeout: got BUSY=1 expected 0 (cycle %0d)", cyc);
    end
  endtask
  task automatic go(int a, int b, bit push);
    wait_idle();
    A = W'(a);
    B = W'(b);
    START = 1'b1;
    @(posedge CLK);
    #1;
    if (push) q.push_back(model(a, b, cyc));
    START = 1'b0;
  endtask
  task automatic check_zero(string n);
    chk({n, "_busy"}, int'(BUSY), 0);
    chk({n, "_done"}, int'(DONE), 0);
    chk({n, "_error"}, int'(ERROR), 0);
    chk({n, "_y"}, int'(Y), 0);
    chk({n, "_iter"}, int'(ITER), 0);
  endtask
  initial begin
    int k, n;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    go(48, 18, 1);
    go(12, 12, 1);
    go(0, 7, 1);
    go(9, 6, 1);
    go(255, 1, 1);
    repeat (3) begin
      repeat (20) @(posedge CLK);
      #1;
      A = 8'd3;
      B = 8'd9;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
    end
    wait_idle();
    A = 8'd8;
    B = 8'd4;
    START = 1'b1;
    @(posedge CLK);
    #1;
    k = cyc;
    q.push_back(model(8, 4, k));
    q.push_back(model(8, 4, k + 4));
    q.push_back(model(8, 4, k + 8));
    repeat (8) @(posedge CLK);
    #1;
    START = 1'b0;
    go(200, 3, 0);
    repeat (5) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check_zero("midcalc_reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (300) @(posedge CLK);
    #1;
    go(36, 24, 1);
    repeat (40) begin
      go(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255),
         ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255), 1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge CLK);
      n++;
    end
    repeat (3) @(posedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
